// File: rtl/rx_drain_ctrl.sv
// Drains completed UART RX frames to a valid/ready consumer. The first byte is valid 4 cycles after a poll expiry, then 1 byte/3 clk.
// While out_ready_i is low the byte and its flags are held and no FIFO read is issued. RX_DRAIN_UNDERRUN_CLR_EN also clears the FIFO on an underrun abort.
module rx_drain_ctrl #(
  parameter int unsigned POLL_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_empty_i,
  output logic        n_rx_rd_o,
  output logic        n_rx_clr_o,
  input  logic [27:0] frame_info_i,
  output logic        n_rd_frame_fifo_o,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_sof_o,
  output logic        out_eof_o,
  output logic [15:0] stamp_o,
  output logic        busy_o,
  output logic [7:0]  underrun_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_HDR,
    S_RD,
    S_CAP,
    S_SEND,
    S_ABORT
  } state_t;

  typedef struct packed {
    logic [11:0] count;
    logic [11:0] ms;
    logic [3:0]  acq;
  } frame_info_t;

  localparam logic [15:0] POLL_LAST = 16'(POLL_DIV - 1);

  state_t      state, state_nxt;
  frame_info_t info;
  logic [15:0] poll_cnt;
  logic [11:0] remaining;
  logic        first;
  logic        poll_hit;
  logic        xfer;

  assign info     = frame_info_i;
  assign poll_hit = (poll_cnt == POLL_LAST);
  assign xfer     = out_valid_o & out_ready_i;
  assign busy_o   = (state != S_IDLE);

  // Strobes decode straight from the registered state, so only one can be low.
  assign n_rd_frame_fifo_o = (state != S_POLL);
  assign n_rx_rd_o         = !((state == S_RD) && !rx_empty_i);
`ifdef RX_DRAIN_UNDERRUN_CLR_EN
  assign n_rx_clr_o        = (state != S_ABORT);
`else
  assign n_rx_clr_o        = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (poll_hit && !rx_empty_i) state_nxt = S_POLL;
      S_POLL:  state_nxt = S_HDR;
      S_HDR:   state_nxt = (info.count == 12'd0) ? S_IDLE : S_RD;
      S_RD:    state_nxt = rx_empty_i ? S_ABORT : S_CAP;
      S_CAP:   state_nxt = S_SEND;
      S_SEND: begin
        if (xfer) state_nxt = (remaining == 12'd1) ? S_IDLE : S_RD;
      end
      S_ABORT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt       <= '0;
      remaining      <= '0;
      first          <= 1'b0;
      out_data_o     <= '0;
      out_valid_o    <= 1'b0;
      out_sof_o      <= 1'b0;
      out_eof_o      <= 1'b0;
      stamp_o        <= '0;
      underrun_cnt_o <= '0;
    end else begin
      // The poll interval always restarts from zero on re-entering IDLE.
      if (state == S_IDLE) begin
        poll_cnt <= poll_hit ? 16'd0 : poll_cnt + 16'd1;
      end else begin
        poll_cnt <= '0;
      end

      case (state)
        S_HDR: begin
          if (info.count != 12'd0) begin
            remaining <= info.count;
            stamp_o   <= {info.ms, info.acq};
            first     <= 1'b1;
          end
        end
        S_CAP: begin
          out_data_o  <= rx_data_i;
          out_sof_o   <= first;
          out_eof_o   <= (remaining == 12'd1);
          out_valid_o <= 1'b1;
        end
        S_SEND: begin
          if (xfer) begin
            out_valid_o <= 1'b0;
            out_sof_o   <= 1'b0;
            out_eof_o   <= 1'b0;
            first       <= 1'b0;
            remaining   <= remaining - 12'd1;
          end
        end
        S_ABORT: begin
          if (underrun_cnt_o != 8'hFF) underrun_cnt_o <= underrun_cnt_o + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_drain_ctrl.sv
// Directed bench for rx_drain_ctrl with a small receive-FIFO responder and a transfer log.
module tb_rx_drain_ctrl;

  localparam int PDIV = 8;
`ifdef RX_DRAIN_UNDERRUN_CLR_EN
  localparam int EXP_CLR = 1;
`else
  localparam int EXP_CLR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_empty_i = 1'b1;
  logic        n_rx_rd_o;
  logic        n_rx_clr_o;
  logic [27:0] frame_info_i = '0;
  logic        n_rd_frame_fifo_o;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic        out_sof_o;
  logic        out_eof_o;
  logic [15:0] stamp_o;
  logic        busy_o;
  logic [7:0]  underrun_cnt_o;

  rx_drain_ctrl #(.POLL_DIV(PDIV)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_data_i        (rx_data_i),
    .rx_empty_i       (rx_empty_i),
    .n_rx_rd_o        (n_rx_rd_o),
    .n_rx_clr_o       (n_rx_clr_o),
    .frame_info_i     (frame_info_i),
    .n_rd_frame_fifo_o(n_rd_frame_fifo_o),
    .out_data_o       (out_data_o),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_sof_o        (out_sof_o),
    .out_eof_o        (out_eof_o),
    .stamp_o          (stamp_o),
    .busy_o           (busy_o),
    .underrun_cnt_o   (underrun_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fq[$];
  logic [9:0] xq[$];
  int         xcyc[$];
  logic [7:0] pend = 8'h00;
  bit         pend_v = 1'b0;
  int cyc = 0, rd_cnt = 0, frm_cnt = 0, clr_cnt = 0, excl_bad = 0;
  int frm_last = 0, frm_prev = 0, v_first = 0;

  // FIFO responder and monitors: data and empty update the cycle after a read.
  always @(negedge clk) begin
    int nlow;
    cyc++;
    nlow = 0;
    if (!n_rx_rd_o) nlow++;
    if (!n_rx_clr_o) nlow++;
    if (!n_rd_frame_fifo_o) nlow++;
    if (nlow > 1) excl_bad++;
    if (!n_rd_frame_fifo_o) begin
      frm_cnt++;
      frm_prev = frm_last;
      frm_last = cyc;
    end
    if (!n_rx_clr_o) clr_cnt++;
    if (out_valid_o && v_first == 0) v_first = cyc;
    if (out_valid_o && out_ready_i) begin
      xq.push_back({out_sof_o, out_eof_o, out_data_o});
      xcyc.push_back(cyc);
    end
    if (pend_v) begin
      rx_data_i = pend;
      pend_v = 1'b0;
    end
    rx_empty_i = (fq.size() == 0);
    if (!n_rx_rd_o) begin
      rd_cnt++;
      pend = (fq.size() != 0) ? fq.pop_front() : 8'hEE;
      pend_v = 1'b1;
    end
    if (!n_rx_clr_o) fq.delete();
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    xq.delete();
    xcyc.delete();
    rd_cnt = 0;
    frm_cnt = 0;
    clr_cnt = 0;
    v_first = 0;
    frm_last = 0;
    frm_prev = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    fq.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic wait_xfers(input string tag, input int n, input int lim);
    for (int i = 0; i < lim && xq.size() < n; i++) tick();
    chk(tag, 32'(xq.size()), 32'(n));
  endtask

  task automatic wait_idle(input string tag, input int lim);
    for (int i = 0; i < lim && busy_o; i++) tick();
    chk(tag, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int lim);
    for (int i = 0; i < lim && !out_valid_o; i++) tick();
    chk(tag, 32'(out_valid_o), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_strobes"}, 32'({n_rx_rd_o, n_rx_clr_o, n_rd_frame_fifo_o}), 32'h7);
    chk({tag, "_flags"}, 32'({out_valid_o, out_sof_o, out_eof_o, busy_o}), 32'h0);
    chk({tag, "_data"}, 32'(out_data_o), 32'h0);
    chk({tag, "_stamp"}, 32'(stamp_o), 32'h0);
    chk({tag, "_underrun"}, 32'(underrun_cnt_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    tick();
    chk_reset_vals("rst");

    // 3-byte frame, consumer always ready
    @(posedge clk); #1;
    clear_logs();
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    frame_info_i = {12'd3, 12'h1F4, 4'd7};
    out_ready_i = 1'b1;
    rst = 1'b0;
    wait_xfers("A_xfers", 3, 300);
    wait_idle("A_idle", 20);
    chk("A_byte0", 32'(xq[0]), 32'h211);
    chk("A_byte1", 32'(xq[1]), 32'h022);
    chk("A_byte2", 32'(xq[2]), 32'h133);
    chk("A_latency", 32'(v_first - frm_last), 32'd4);
    chk("A_tput", 32'(xcyc[2] - xcyc[0]), 32'd6);
    chk("A_stamp", 32'(stamp_o), 32'h1F47);
    chk("A_rd", 32'(rd_cnt), 32'd3);
    chk("A_frm", 32'(frm_cnt), 32'd1);
    repeat (30) tick();
    chk("A_nopoll_empty", 32'(frm_cnt), 32'd1);

    // Same frame with byte 2 stalled
    do_reset();
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    frame_info_i = {12'd3, 12'h1F4, 4'd7};
    out_ready_i = 1'b0;
    wait_valid("B_v0", 300);
    @(posedge clk); #1; out_ready_i = 1'b1;
    @(posedge clk); #1; out_ready_i = 1'b0;
    wait_valid("B_v1", 50);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("B_hold", 32'({out_valid_o, out_sof_o, out_eof_o, out_data_o}), 32'h422);
    end
    chk("B_rd_stall", 32'(rd_cnt), 32'd2);
    @(posedge clk); #1; out_ready_i = 1'b1;
    wait_xfers("B_xfers", 3, 100);
    wait_idle("B_idle", 20);
    chk("B_byte1", 32'(xq[1]), 32'h022);
    chk("B_byte2", 32'(xq[2]), 32'h133);
    chk("B_rd", 32'(rd_cnt), 32'd3);

    // Zero-count header with data present: periodic polls only
    do_reset();
    fq.push_back(8'h5A);
    frame_info_i = {12'd0, 12'h000, 4'd0};
    for (int i = 0; i < 100 && frm_cnt < 1; i++) tick();
    repeat (30) tick();
    chk("C_polls", 32'(frm_cnt), 32'd4);
    chk("C_period", 32'(frm_last - frm_prev), 32'(PDIV + 2));
    chk("C_rd", 32'(rd_cnt), 32'd0);

    // Underrun: count 4 with only 2 bytes
    do_reset();
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    frame_info_i = {12'd4, 12'h010, 4'd1};
    out_ready_i = 1'b1;
    for (int i = 0; i < 300 && underrun_cnt_o == 8'd0; i++) tick();
    chk("D_underrun", 32'(underrun_cnt_o), 32'd1);
    repeat (5) tick();
    chk("D_xfers", 32'(xq.size()), 32'd2);
    chk("D_byte0", 32'(xq[0]), 32'h2AA);
    chk("D_byte1", 32'(xq[1]), 32'h0BB);
    chk("D_rd", 32'(rd_cnt), 32'd2);
    chk("D_clr", 32'(clr_cnt), 32'(EXP_CLR));
    chk("D_stamp", 32'(stamp_o), 32'h0101);
    chk("D_busy", 32'(busy_o), 32'd0);

    // Reset while a byte is offered
    @(posedge clk); #1;
    clear_logs();
    fq.push_back(8'h01); fq.push_back(8'h02);
    frame_info_i = {12'd2, 12'h123, 4'd4};
    out_ready_i = 1'b0;
    wait_valid("E_valid", 300);
    chk("E_offer", 32'({out_sof_o, out_eof_o, out_data_o}), 32'h201);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    tick();
    chk_reset_vals("E_rst");
    @(posedge clk); #1;
    fq.delete();
    rst = 1'b0;

    // Single-byte frame
    do_reset();
    fq.push_back(8'h7E);
    frame_info_i = {12'd1, 12'hABC, 4'd3};
    out_ready_i = 1'b1;
    wait_xfers("F_xfers", 1, 300);
    wait_idle("F_idle", 20);
    chk("F_byte", 32'(xq[0]), 32'h37E);
    chk("F_stamp", 32'(stamp_o), 32'hABC3);
    chk("F_rd", 32'(rd_cnt), 32'd1);

    chk("strobe_exclusive", 32'(excl_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
